// File: rtl/lcd_nibble_sender.sv
// Byte-to-nibble transmitter for a 4-bit HD44780-style LCD bus.
// Drives DB7..DB4 and E with setup, pulse, inter-nibble and post-command timing.
module lcd_nibble_sender #(
  parameter int unsigned SETUP_CYCLES      = 2,
  parameter int unsigned E_HIGH_CYCLES     = 12,
  parameter int unsigned NIBBLE_GAP_CYCLES = 50,
  parameter int unsigned CMD_WAIT_CYCLES   = 2000
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       iWriteBegin,
  input  logic [7:0] iData,
  output logic [3:0] oSender,
  output logic       oLCD_EN,
  output logic       oWriteDone,
  output logic       oBusy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP_H,
    S_E_H,
    S_GAP,
    S_SETUP_L,
    S_E_L,
    S_WAIT,
    S_DONE
  } state_t;

  localparam logic [15:0] L_SETUP = 16'(SETUP_CYCLES - 1);
  localparam logic [15:0] L_EHIGH = 16'(E_HIGH_CYCLES - 1);
  localparam logic [15:0] L_GAP   = 16'(NIBBLE_GAP_CYCLES - 1);
  localparam logic [15:0] L_WAIT  = 16'(CMD_WAIT_CYCLES - 1);

  state_t      r_state;
  state_t      w_next;
  logic [15:0] r_cnt;
  logic [15:0] w_limit;
  logic        w_expired;
  logic [7:0]  r_latch;
  logic [7:0]  w_byte;

  always_comb begin
    w_limit = '0;
    unique case (r_state)
      S_SETUP_H, S_SETUP_L: w_limit = L_SETUP;
      S_E_H, S_E_L:         w_limit = L_EHIGH;
      S_GAP:                w_limit = L_GAP;
      S_WAIT:               w_limit = L_WAIT;
      default:              w_limit = '0;
    endcase
    w_expired = (r_cnt == w_limit);

    w_next = r_state;
    unique case (r_state)
      S_IDLE:    if (iWriteBegin) w_next = S_SETUP_H;
      S_SETUP_H: if (w_expired)   w_next = S_E_H;
      S_E_H:     if (w_expired)   w_next = S_GAP;
      S_GAP:     if (w_expired)   w_next = S_SETUP_L;
      S_SETUP_L: if (w_expired)   w_next = S_E_L;
      S_E_L:     if (w_expired)   w_next = S_WAIT;
      S_WAIT:    if (w_expired)   w_next = S_DONE;
      S_DONE:                     w_next = S_IDLE;
      default:                    w_next = S_IDLE;
    endcase

    // On the accepting edge the latch is not yet loaded, so outputs use iData directly.
    w_byte = (r_state == S_IDLE) ? iData : r_latch;
  end

  // Outputs are registered from the next state so they line up with the state they describe.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_latch    <= '0;
      oSender    <= '0;
      oLCD_EN    <= 1'b0;
      oWriteDone <= 1'b0;
      oBusy      <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == S_IDLE && iWriteBegin) r_latch <= iData;
      if (w_next != r_state || r_state == S_IDLE) r_cnt <= '0;
      else                                        r_cnt <= r_cnt + 16'd1;

      unique case (w_next)
        S_SETUP_H, S_E_H, S_GAP: oSender <= w_byte[7:4];
        S_SETUP_L, S_E_L, S_WAIT, S_DONE: oSender <= w_byte[3:0];
        default: oSender <= '0;
      endcase
      oLCD_EN    <= (w_next == S_E_H) || (w_next == S_E_L);
      oWriteDone <= (w_next == S_DONE);
      oBusy      <= (w_next != S_IDLE);
    end
  end

endmodule

// File: tb/tb_lcd_nibble_sender.sv
// Scoreboard bench for lcd_nibble_sender: stimulus pushes expected E pulses and
// done cycles; a negedge monitor pops and compares them as the DUT produces them.
module tb_lcd_nibble_sender;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       wb1, wb2;
  logic [7:0] din;
  logic [3:0] snd1, snd2;
  logic       en1, en2, dn1, dn2, bz1, bz2;

  always #10 clk = ~clk;

  lcd_nibble_sender dut1 (
    .Clock(clk), .Reset(rst_n), .iWriteBegin(wb1), .iData(din),
    .oSender(snd1), .oLCD_EN(en1), .oWriteDone(dn1), .oBusy(bz1)
  );

  lcd_nibble_sender #(
    .SETUP_CYCLES(1), .E_HIGH_CYCLES(1), .NIBBLE_GAP_CYCLES(1), .CMD_WAIT_CYCLES(1)
  ) dut2 (
    .Clock(clk), .Reset(rst_n), .iWriteBegin(wb2), .iData(din),
    .oSender(snd2), .oLCD_EN(en2), .oWriteDone(dn2), .oBusy(bz2)
  );

  typedef struct {
    bit       is_done;
    logic [3:0] nib;
    int       cyc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   edge_n = 0;
  int   done_cnt = 0;
  bit   sel = 1'b0;

  logic [3:0] m_snd;
  logic       m_en, m_done;
  assign m_snd  = sel ? snd2 : snd1;
  assign m_en   = sel ? en2  : en1;
  assign m_done = sel ? dn2  : dn1;

  always @(posedge clk) edge_n <= edge_n + 1;

  function automatic int p_s();  return sel ? 1 : 2;    endfunction
  function automatic int p_e();  return sel ? 1 : 12;   endfunction
  function automatic int p_g();  return sel ? 1 : 50;   endfunction
  function automatic int p_w();  return sel ? 1 : 2000; endfunction
  function automatic int lat();  return 1 + 2*p_s() + 2*p_e() + p_g() + p_w(); endfunction

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, expv, $time);
    end
  endtask

  // acc is the edge count right after the accepting edge; relative cycle r is at label acc-1+r.
  task automatic push_exp(input logic [7:0] b, input int acc);
    exp_t e;
    int base;
    base = acc - 1;
    e.is_done = 1'b0; e.nib = b[7:4]; e.cyc = base + 1 + p_s();
    sb.push_back(e);
    e.is_done = 1'b0; e.nib = b[3:0]; e.cyc = base + 1 + 2*p_s() + p_e() + p_g();
    sb.push_back(e);
    e.is_done = 1'b1; e.nib = 4'h0;   e.cyc = base + lat();
    sb.push_back(e);
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!m_done && n < budget);
    if (!m_done) chk("done_timeout", 0, 1);
  endtask

  // Monitor: protocol checks plus scoreboard comparison of every E pulse and done pulse.
  logic [3:0] prev_snd = 4'h0;
  logic       prev_en = 1'b0;
  logic       prev_done = 1'b0;
  int         stable = 0;
  int         p_start = 0;
  logic [3:0] p_nib = 4'h0;

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      prev_snd  = 4'h0;
      prev_en   = 1'b0;
      prev_done = 1'b0;
      stable    = 0;
    end else begin
      if (m_en && !prev_en) begin
        chk("setup_stable", ((m_snd == prev_snd) && (stable >= p_s())) ? 1 : 0, 1);
        p_start = edge_n;
        p_nib   = m_snd;
      end
      if (m_en && prev_en) chk("e_data_stable", int'(m_snd), int'(prev_snd));
      if (!m_en && prev_en) begin
        chk("e_hold_nibble", int'(m_snd), int'(p_nib));
        if (sb.size() == 0 || sb[0].is_done) chk("unexpected_e_pulse", 1, 0);
        else begin
          e = sb.pop_front();
          chk("e_nibble", int'(p_nib), int'(e.nib));
          chk("e_start", p_start, e.cyc);
          chk("e_width", edge_n - p_start, p_e());
        end
      end
      if (m_done) begin
        chk("done_single_cycle", int'(prev_done), 0);
        done_cnt++;
        if (sb.size() == 0 || !sb[0].is_done) chk("unexpected_done", 1, 0);
        else begin
          e = sb.pop_front();
          chk("done_cycle", edge_n, e.cyc);
        end
      end
      stable    = (m_snd == prev_snd) ? stable + 1 : 1;
      prev_snd  = m_snd;
      prev_en   = m_en;
      prev_done = m_done;
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int a, base, n0;
    rst_n = 1'b0; wb1 = 1'b0; wb2 = 1'b0; din = 8'h00; sel = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_sender1", int'(snd1), 0);
    chk("rst_en1", int'(en1), 0);
    chk("rst_done1", int'(dn1), 0);
    chk("rst_busy1", int'(bz1), 0);
    chk("rst_sender2", int'(snd2), 0);
    chk("rst_busy2", int'(bz2), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Single transfer of 0x28.
    din = 8'h28; wb1 = 1'b1;
    @(posedge clk); #1;
    a = edge_n; wb1 = 1'b0;
    push_exp(8'h28, a);
    wait_done(3000);
    repeat (2) @(negedge clk);
    chk("idle_after_28", int'(bz1), 0);

    // Back-to-back with iWriteBegin held high: 0x06 then 0x0C.
    din = 8'h06; wb1 = 1'b1;
    @(posedge clk); #1;
    a = edge_n;
    push_exp(8'h06, a);
    wait_done(3000);
    din = 8'h0C;
    push_exp(8'h0C, a + lat() + 1);
    wait_done(3000);
    wb1 = 1'b0;
    repeat (2) @(negedge clk);
    chk("idle_after_b2b", int'(bz1), 0);

    // Reset in the middle of the lower-nibble E pulse.
    din = 8'h28; wb1 = 1'b1;
    @(posedge clk); #1;
    a = edge_n; wb1 = 1'b0;
    push_exp(8'h28, a);
    base = a - 1;
    while (edge_n < base + 70) @(negedge clk);
    chk("e_l_active_at_70", int'(en1), 1);
    n0 = done_cnt;
    sb.delete();
    rst_n = 1'b0;
    #1;
    chk("async_rst_en", int'(en1), 0);
    chk("async_rst_sender", int'(snd1), 0);
    chk("async_rst_busy", int'(bz1), 0);
    chk("async_rst_done", int'(dn1), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (60) @(negedge clk);
    chk("post_rst_idle_busy", int'(bz1), 0);
    chk("post_rst_sender", int'(snd1), 0);
    chk("post_rst_no_done", done_cnt, n0);

    // Reset released with iWriteBegin high; inputs disturbed during GAP.
    rst_n = 1'b0; din = 8'h5A; wb1 = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    a = edge_n;
    chk("accept_after_release_busy", int'(bz1), 1);
    chk("accept_after_release_sender", int'(snd1), 5);
    push_exp(8'h5A, a);
    while (edge_n < a - 1 + 30) @(negedge clk);
    din = 8'hFF; wb1 = 1'b0;
    n0 = done_cnt;
    wait_done(3000);
    repeat (2) @(negedge clk);
    chk("gap_disturb_one_done", done_cnt, n0 + 1);
    chk("idle_after_5a", int'(bz1), 0);

    // Minimum timing instance.
    sel = 1'b1;
    @(negedge clk);
    din = 8'hC3; wb2 = 1'b1;
    @(posedge clk); #1;
    a = edge_n; wb2 = 1'b0;
    push_exp(8'hC3, a);
    wait_done(50);
    repeat (2) @(negedge clk);
    chk("idle_after_c3", int'(bz2), 0);

    repeat (5) @(negedge clk);
    chk("scoreboard_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/lcd_nibble_sender.md
# lcd_nibble_sender

Byte-to-nibble transmitter for the 4-bit HD44780-style character LCD interface on the 50 MHz board clock. It sits directly downstream of the LCD control FSM: the FSM presents one 8-bit command or character plus a start strobe. This block then drives the LCD data nibble and enable line with datasheet-compliant setup, pulse-width, inter-nibble and post-command timing, and returns a one-cycle completion pulse. RS and R/W stay owned by the control FSM; this block only sequences the data and E lines.

## Interface
- SETUP_CYCLES, 2: data-valid cycles before E rises (≥40 ns); must be ≥1.
- E_HIGH_CYCLES, 12: E high width per nibble (≥230 ns); must be ≥1.
- NIBBLE_GAP_CYCLES, 50: cycles from E falling on the upper nibble to the start of lower-nibble setup (≥1 µs); must be ≥1.
- CMD_WAIT_CYCLES, 2000: cycles after the lower-nibble E falls before done (≥40 µs); must be ≥1 and ≤65535.

- Clock  in  1  system clock, rising-edge.
- Reset  in  1  asynchronous, active-low; 0 forces IDLE immediately.
- iWriteBegin  in  1  start request; sampled only in IDLE.
- iData  in  8  byte to send; captured on the accepting edge.
- oSender  out  4  LCD data nibble (DB7..DB4).
- oLCD_EN  out  1  LCD enable (E).
- oWriteDone  out  1  one-cycle pulse when the transfer completes.
- oBusy  out  1  high in every state except IDLE.

## Operation
- Reset values: state=IDLE, oSender=0, oLCD_EN=0, oWriteDone=0, oBusy=0, byte latch=0, counter=0.
- States: IDLE → SETUP_H → E_H → GAP → SETUP_L → E_L → WAIT → DONE → IDLE.
- IDLE: if iWriteBegin=1, latch iData, clear the counter and go to SETUP_H. Otherwise stay.
- Each timed state lasts exactly its parameter count: SETUP_H/SETUP_L use SETUP_CYCLES, E_H/E_L use E_HIGH_CYCLES, GAP uses NIBBLE_GAP_CYCLES, WAIT uses CMD_WAIT_CYCLES. A single 16-bit counter is cleared on every state change.
- oSender = latch[7:4] in SETUP_H, E_H and GAP; latch[3:0] in SETUP_L, E_L, WAIT and DONE; 0 in IDLE. Data is held ≥1 cycle after E falls.
- oLCD_EN = 1 only in E_H and E_L.
- DONE lasts 1 cycle with oWriteDone=1, then the block returns to IDLE.
- iData and iWriteBegin changes after acceptance are ignored; a transfer always runs to completion.
- iWriteBegin held high continuously starts a new transfer from IDLE on the cycle after DONE, latching iData as presented then. The control FSM changes iData in the same cycle it observes oWriteDone.
- All outputs are registered; there are no combinational paths from the inputs to the outputs.

## Timing
- Acceptance edge = cycle 0. With defaults: SETUP_H cycles 1–2, E_H 3–14, GAP 15–64, SETUP_L 65–66, E_L 67–78, WAIT 79–2078, DONE (oWriteDone=1) cycle 2079.
- General latency from acceptance to oWriteDone = 1 + 2·SETUP + 2·E_HIGH + GAP + WAIT cycles.
- Minimum back-to-back period = latency + 1 cycle, because IDLE is re-entered for one cycle.
- Reset low mid-transfer: all outputs go to their reset values asynchronously, no oWriteDone is issued, and the partial byte is abandoned.
- Reset release with iWriteBegin=1: acceptance occurs on the first rising edge after deassertion.

## Test plan
- Reset, then iWriteBegin=1 with iData=8'h28 for one cycle → oSender=4'h2 with an E pulse of 12 cycles starting at cycle 3, then oSender=4'h8 with an E pulse over cycles 67–78, and oWriteDone high only at cycle 2079.
- iWriteBegin held high: iData=8'h06, then 8'h0C after the first oWriteDone → two complete transfers, the second accepted exactly 1 cycle after the first DONE, nibbles 0,6 then 0,C.
- iData toggled to 8'hFF and iWriteBegin dropped during GAP of a transfer of 8'h5A → lower nibble is still 4'hA and oWriteDone still fires once.
- Reset asserted low at cycle 70 (during E_L) → oLCD_EN, oSender, oBusy go to 0 before the next edge, no oWriteDone pulse, and IDLE is held until iWriteBegin.
- Parameters overridden to 1/1/1/1 with iData=8'hC3 → nibbles C then 3, each with a 1-cycle E pulse, oWriteDone at cycle 7.
- Checker: oLCD_EN is never high while oSender changes, and every E pulse is preceded by ≥SETUP_CYCLES of stable data.
